// File: rtl/cpu_pkg.sv
// ============================================================
// cpu_pkg : shared widths and pipeline state encodings
// Rev 1.0
// ============================================================
`default_nettype none

package cpu_pkg;

  localparam int WORD_W = 16;
  localparam int REG_W  = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } state_e;

  localparam logic [1:0] ST_IDLE = IDLE;
  localparam logic [1:0] ST_REQ  = REQ;
  localparam logic [1:0] ST_RESP = RESP;

endpackage

`default_nettype wire

// File: rtl/mem_stage_if.sv
// ============================================================
// mem_stage_if : single-outstanding request/grant/response data bus
// Rev 1.0
// ============================================================
`default_nettype none

interface mem_stage_if;
  import cpu_pkg::*;

  logic              mem_req;
  logic              mem_we;
  logic [WORD_W-1:0] mem_addr;
  logic [WORD_W-1:0] mem_wdata;
  logic              mem_gnt;
  logic              mem_rvalid;
  logic [WORD_W-1:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_gnt, mem_rvalid, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_gnt, mem_rvalid, mem_rdata
  );

endinterface

`default_nettype wire

// File: rtl/mem_timeout_ctr.sv
// ============================================================
// mem_timeout_ctr : saturating wait counter, expired at TIMEOUT
// Rev 1.0
// ============================================================
`default_nettype none

module mem_timeout_ctr #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] C_MAX = CNT_W'(TIMEOUT);

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (clr) begin
      r_count <= '0;
    end else if (en && (r_count != C_MAX)) begin
      r_count <= r_count + CNT_W'(1);
    end
  end

  generate
    if (TIMEOUT > 0) begin : g_timeout
      assign expired = (r_count == C_MAX);
    end else begin : g_no_timeout
      assign expired = 1'b0;
    end
  endgenerate

endmodule

`default_nettype wire

// File: rtl/mem_stage.sv
// ============================================================
// mem_stage : memory-access stage, ALU result -> bus -> writeback
// Rev 1.0
// ============================================================
`default_nettype none

module mem_stage
  import cpu_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ex_valid,
  output logic              ex_ready,
  input  logic              ex_load,
  input  logic              ex_store,
  input  logic [WORD_W-1:0] ex_result,
  input  logic [WORD_W-1:0] ex_store_data,
  input  logic [REG_W-1:0]  ex_rd,
  mem_stage_if.master       bus,
  output logic              wb_valid,
  output logic              wb_we,
  output logic [REG_W-1:0]  wb_rd,
  output logic [WORD_W-1:0] wb_data,
  output logic              bus_err
);

  logic [1:0]       r_state;
  logic             r_load;
  logic [REG_W-1:0] r_rd;

  logic w_accept;
  logic w_mem_op;
  logic w_clr;
  logic w_expired;

  assign ex_ready = rst_n && (r_state == ST_IDLE);
  assign w_accept = ex_valid && ex_ready;
  assign w_mem_op = ex_load || ex_store;
  // Counter restarts both when the request is issued and when the grant moves a load to RESP
  assign w_clr    = (w_accept && w_mem_op) ||
                    ((r_state == ST_REQ) && bus.mem_gnt && r_load);

  mem_timeout_ctr #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (w_clr),
    .en      (r_state != ST_IDLE),
    .expired (w_expired)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= ST_IDLE;
      r_load        <= 1'b0;
      r_rd          <= '0;
      bus.mem_req   <= 1'b0;
      bus.mem_we    <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
      wb_valid      <= 1'b0;
      wb_we         <= 1'b0;
      wb_rd         <= '0;
      wb_data       <= '0;
      bus_err       <= 1'b0;
    end else begin
      wb_valid <= 1'b0;
      wb_we    <= 1'b0;
      bus_err  <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            if (w_mem_op) begin
              r_state       <= ST_REQ;
              r_load        <= ex_load;
              r_rd          <= ex_rd;
              bus.mem_req   <= 1'b1;
              bus.mem_we    <= !ex_load;
              bus.mem_addr  <= ex_result;
              bus.mem_wdata <= ex_store_data;
            end else begin
              wb_valid <= 1'b1;
              wb_we    <= (ex_rd != '0);
              wb_rd    <= ex_rd;
              wb_data  <= ex_result;
            end
          end
        end
        ST_REQ: begin
          // A grant in the expiry cycle takes priority over the timeout
          if (bus.mem_gnt) begin
            bus.mem_req <= 1'b0;
            if (r_load) begin
              r_state <= ST_RESP;
            end else begin
              r_state  <= ST_IDLE;
              wb_valid <= 1'b1;
              wb_rd    <= r_rd;
            end
          end else if (w_expired) begin
            bus.mem_req <= 1'b0;
            r_state     <= ST_IDLE;
            wb_valid    <= 1'b1;
            wb_rd       <= r_rd;
            bus_err     <= 1'b1;
          end
        end
        ST_RESP: begin
          if (bus.mem_rvalid) begin
            r_state  <= ST_IDLE;
            wb_valid <= 1'b1;
            wb_we    <= (r_rd != '0);
            wb_rd    <= r_rd;
            wb_data  <= bus.mem_rdata;
          end else if (w_expired) begin
            r_state  <= ST_IDLE;
            wb_valid <= 1'b1;
            wb_rd    <= r_rd;
            bus_err  <= 1'b1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mem_stage.sv
// ============================================================
// tb_mem_stage : directed stimulus with writeback scoreboard
// Rev 1.0
// ============================================================
`default_nettype none

module tb_mem_stage;
  import cpu_pkg::*;

  typedef struct packed {
    logic              we;
    logic [REG_W-1:0]  rd;
    logic [WORD_W-1:0] data;
    logic              chk_data;
    logic              err;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst_n = 1'b1;
  logic              ex_valid = 1'b0;
  logic              ex_ready;
  logic              ex_load = 1'b0;
  logic              ex_store = 1'b0;
  logic [WORD_W-1:0] ex_result = '0;
  logic [WORD_W-1:0] ex_store_data = '0;
  logic [REG_W-1:0]  ex_rd = '0;
  logic              wb_valid;
  logic              wb_we;
  logic [REG_W-1:0]  wb_rd;
  logic [WORD_W-1:0] wb_data;
  logic              bus_err;

  int   n_cmp  = 0;
  int   n_fail = 0;
  exp_t exp_q[$];
  exp_t e_mon;

  mem_stage_if bus();

  mem_stage #(.TIMEOUT(4)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .ex_valid      (ex_valid),
    .ex_ready      (ex_ready),
    .ex_load       (ex_load),
    .ex_store      (ex_store),
    .ex_result     (ex_result),
    .ex_store_data (ex_store_data),
    .ex_rd         (ex_rd),
    .bus           (bus),
    .wb_valid      (wb_valid),
    .wb_we         (wb_we),
    .wb_rd         (wb_rd),
    .wb_data       (wb_data),
    .bus_err       (bus_err)
  );

  always #5 clk = ~clk;

  task automatic chk1(input string nm, input logic act, input logic expv);
    n_cmp++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b (t=%0t)", nm, act, expv, $time);
    end
  endtask

  task automatic chk16(input string nm, input logic [15:0] act, input logic [15:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, expv, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic alu(input logic [REG_W-1:0] rd, input logic [WORD_W-1:0] res);
    ex_valid  = 1'b1;
    ex_load   = 1'b0;
    ex_store  = 1'b0;
    ex_rd     = rd;
    ex_result = res;
    exp_q.push_back('{we: (rd != 0), rd: rd, data: res, chk_data: 1'b1, err: 1'b0});
  endtask

  task automatic memop(input logic ld, input logic st, input logic [WORD_W-1:0] addr,
                       input logic [WORD_W-1:0] wdata, input logic [REG_W-1:0] rd);
    ex_valid      = 1'b1;
    ex_load       = ld;
    ex_store      = st;
    ex_result     = addr;
    ex_store_data = wdata;
    ex_rd         = rd;
  endtask

  task automatic idle_ex;
    ex_valid = 1'b0;
    ex_load  = 1'b0;
    ex_store = 1'b0;
  endtask

  // Monitor: every writeback pulse must match the oldest expected packet
  always @(negedge clk) begin
    if (rst_n && wb_valid) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL unexpected_wb: got rd=%0d data=%h expected no writeback (t=%0t)",
                 wb_rd, wb_data, $time);
      end else begin
        e_mon = exp_q.pop_front();
        chk1("wb_we", wb_we, e_mon.we);
        chk16("wb_rd", 16'(wb_rd), 16'(e_mon.rd));
        if (e_mon.chk_data) chk16("wb_data", wb_data, e_mon.data);
        chk1("bus_err", bus_err, e_mon.err);
      end
    end else if (rst_n && bus_err) begin
      n_cmp++;
      n_fail++;
      $display("FAIL lone_bus_err: got bus_err=1 expected 0 without wb_valid (t=%0t)", $time);
    end
  end

  initial begin
    bus.mem_gnt    = 1'b0;
    bus.mem_rvalid = 1'b0;
    bus.mem_rdata  = '0;

    #3 rst_n = 1'b0;
    @(negedge clk);
    chk1("rst_ex_ready", ex_ready, 1'b0);
    chk1("rst_mem_req", bus.mem_req, 1'b0);
    chk1("rst_wb_valid", wb_valid, 1'b0);
    chk16("rst_mem_addr", bus.mem_addr, 16'h0000);
    tick;
    rst_n = 1'b1;
    @(negedge clk);
    chk1("post_rst_ex_ready", ex_ready, 1'b1);

    // ALU passthrough, back to back
    tick; alu(3'd1, 16'h1234);
    tick; alu(3'd2, 16'hFFFF);
    @(negedge clk); chk1("alu_wb1", wb_valid, 1'b1); chk1("alu_rdy1", ex_ready, 1'b1);
    tick; alu(3'd3, 16'h0000);
    @(negedge clk); chk1("alu_wb2", wb_valid, 1'b1); chk1("alu_rdy2", ex_ready, 1'b1);
    tick; idle_ex;
    @(negedge clk); chk1("alu_wb3", wb_valid, 1'b1);
    tick;
    @(negedge clk); chk1("alu_wb_end", wb_valid, 1'b0);

    // Store with grant two cycles late
    memop(1'b0, 1'b1, 16'h00A0, 16'hBEEF, 3'd4);
    exp_q.push_back('{we: 1'b0, rd: 3'd4, data: 16'h0, chk_data: 1'b0, err: 1'b0});
    tick; idle_ex;
    for (int i = 0; i < 3; i++) begin
      if (i == 2) bus.mem_gnt = 1'b1;
      @(negedge clk);
      chk1("st_req", bus.mem_req, 1'b1);
      chk1("st_we", bus.mem_we, 1'b1);
      chk16("st_addr", bus.mem_addr, 16'h00A0);
      chk16("st_wdata", bus.mem_wdata, 16'hBEEF);
      chk1("st_ready", ex_ready, 1'b0);
      chk1("st_no_wb", wb_valid, 1'b0);
      tick;
    end
    bus.mem_gnt = 1'b0;
    @(negedge clk);
    chk1("st_req_drop", bus.mem_req, 1'b0);
    chk1("st_wb", wb_valid, 1'b1);
    chk1("st_ready_back", ex_ready, 1'b1);

    // Load, immediate grant with spurious rvalid, data four cycles later
    tick; memop(1'b1, 1'b0, 16'h0100, 16'h0000, 3'd5);
    exp_q.push_back('{we: 1'b1, rd: 3'd5, data: 16'hCAFE, chk_data: 1'b1, err: 1'b0});
    tick; idle_ex;
    bus.mem_gnt = 1'b1; bus.mem_rvalid = 1'b1; bus.mem_rdata = 16'hDEAD;
    @(negedge clk);
    chk1("ld_req", bus.mem_req, 1'b1);
    chk1("ld_we", bus.mem_we, 1'b0);
    chk16("ld_addr", bus.mem_addr, 16'h0100);
    tick;
    bus.mem_gnt = 1'b0; bus.mem_rvalid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk1("ld_wait_wb", wb_valid, 1'b0);
      chk1("ld_wait_rdy", ex_ready, 1'b0);
      chk1("ld_wait_req", bus.mem_req, 1'b0);
      tick;
    end
    bus.mem_rvalid = 1'b1; bus.mem_rdata = 16'hCAFE;
    @(negedge clk); chk1("ld_resp_rdy", ex_ready, 1'b0);
    tick; bus.mem_rvalid = 1'b0;
    @(negedge clk); chk1("ld_wb", wb_valid, 1'b1); chk1("ld_rdy_back", ex_ready, 1'b1);

    // rd=0 load with load+store both set, minimum latency
    tick; memop(1'b1, 1'b1, 16'h0110, 16'h9999, 3'd0);
    exp_q.push_back('{we: 1'b0, rd: 3'd0, data: 16'h5555, chk_data: 1'b1, err: 1'b0});
    tick; idle_ex; bus.mem_gnt = 1'b1;
    @(negedge clk); chk1("ld0_we", bus.mem_we, 1'b0);
    tick; bus.mem_gnt = 1'b0; bus.mem_rvalid = 1'b1; bus.mem_rdata = 16'h5555;
    @(negedge clk); chk1("ld0_early", wb_valid, 1'b0);
    tick; bus.mem_rvalid = 1'b0;
    @(negedge clk); chk1("ld0_min_lat", wb_valid, 1'b1);

    // Timeout with no grant
    tick; memop(1'b0, 1'b1, 16'h0200, 16'h1111, 3'd6);
    exp_q.push_back('{we: 1'b0, rd: 3'd6, data: 16'h0, chk_data: 1'b0, err: 1'b1});
    tick; idle_ex;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk1("to_req", bus.mem_req, 1'b1);
      chk1("to_no_err", bus_err, 1'b0);
      tick;
    end
    @(negedge clk);
    chk1("to_req_drop", bus.mem_req, 1'b0);
    chk1("to_err", bus_err, 1'b1);
    chk1("to_rdy", ex_ready, 1'b1);

    // Grant in the expiry cycle beats the timeout
    tick; memop(1'b0, 1'b1, 16'h0204, 16'h2222, 3'd7);
    exp_q.push_back('{we: 1'b0, rd: 3'd7, data: 16'h0, chk_data: 1'b0, err: 1'b0});
    tick; idle_ex;
    for (int i = 0; i < 5; i++) begin
      if (i == 4) bus.mem_gnt = 1'b1;
      @(negedge clk);
      chk1("tg_req", bus.mem_req, 1'b1);
      tick;
    end
    bus.mem_gnt = 1'b0;
    @(negedge clk);
    chk1("tg_no_err", bus_err, 1'b0);
    chk1("tg_wb", wb_valid, 1'b1);

    // Reset while in RESP
    tick; memop(1'b1, 1'b0, 16'h0300, 16'h0000, 3'd3);
    tick; idle_ex; bus.mem_gnt = 1'b1;
    tick; bus.mem_gnt = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk1("mid_rst_ready", ex_ready, 1'b0);
    chk1("mid_rst_req", bus.mem_req, 1'b0);
    chk16("mid_rst_addr", bus.mem_addr, 16'h0000);
    chk16("mid_rst_wb_data", wb_data, 16'h0000);
    chk1("mid_rst_wb_valid", wb_valid, 1'b0);
    tick;
    rst_n = 1'b1; bus.mem_rvalid = 1'b1; bus.mem_rdata = 16'h7777;
    @(negedge clk); chk1("late_rvalid_wb", wb_valid, 1'b0); chk1("late_rdy", ex_ready, 1'b1);
    tick; bus.mem_rvalid = 1'b0;
    @(negedge clk); chk1("late_rvalid_wb2", wb_valid, 1'b0);
    alu(3'd2, 16'h0042);
    tick; idle_ex;
    @(negedge clk); chk1("post_rst_alu", wb_valid, 1'b1);

    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge clk);
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending writebacks expected 0", exp_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/mem_stage.md
# mem_stage

Memory-access stage of the 16-bit pipeline, directly downstream of the ALU. It takes the ALU result together with the decoded load/store controls from the execute stage. Loads and stores run on a single-outstanding request/grant/response data bus. The stage then delivers a registered writeback packet for the register file. While a memory access is pending it stalls the execute stage through `ex_ready`.

## Interface
Parameters:
- `TIMEOUT`, 255: max cycles spent waiting for grant or response before a bus error; 0 disables the timeout.

Ports (clock and reset are fixed; every other port is active-high):
- `clk`  in  1  single clock, all state on rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `ex_valid`  in  1  execute stage presents an instruction
- `ex_ready`  out  1  stage can accept this cycle
- `ex_load`  in  1  instruction is a load; address = `ex_result`
- `ex_store`  in  1  instruction is a store; address = `ex_result`
- `ex_result`  in  16  ALU result (data or address)
- `ex_store_data`  in  16  store data (rB value)
- `ex_rd`  in  3  destination register index
- `mem_req`  out  1  bus request, held until granted
- `mem_we`  out  1  1 = write
- `mem_addr`  out  16  word address
- `mem_wdata`  out  16  write data
- `mem_gnt`  in  1  request accepted this cycle
- `mem_rvalid`  in  1  read data valid
- `mem_rdata`  in  16  read data
- `wb_valid`  out  1  writeback packet valid, one-cycle pulse
- `wb_we`  out  1  register write enable
- `wb_rd`  out  3  destination register
- `wb_data`  out  16  writeback value
- `bus_err`  out  1  one-cycle pulse on timeout

## Operation
- FSM states: IDLE, REQ, RESP.
- Transfer: an instruction is accepted when `ex_valid && ex_ready` at a rising edge. `ex_ready` = (state == IDLE).
- `ex_load && ex_store` both set: the instruction is treated as a load.
- Non-memory instruction:
  - Registered to writeback on acceptance: `wb_data` = `ex_result`, `wb_we` = (`ex_rd` != 0).
  - State stays IDLE.
- Store, IDLE -> REQ:
  - On acceptance, drive `mem_req` = 1, `mem_we` = 1, `mem_addr` = `ex_result`, `mem_wdata` = `ex_store_data`.
  - In REQ with `mem_gnt`: drop `mem_req`, pulse `wb_valid` with `wb_we` = 0, return to IDLE.
- Load, IDLE -> REQ -> RESP:
  - In REQ, `mem_we` = 0. On `mem_gnt`, drop `mem_req` and go to RESP.
  - In RESP with `mem_rvalid`: `wb_data` = `mem_rdata`, `wb_we` = (`ex_rd` != 0), pulse `wb_valid`, return to IDLE.
- `mem_rvalid` is ignored outside RESP, including in the grant cycle itself.
- Register r0 is hardwired zero, so `wb_we` is never asserted for rd = 0.
- Bus signals (`mem_req`, `mem_we`, `mem_addr`, `mem_wdata`) are registered and stable from request until grant.
- Timeout:
  - The counter clears on entry to REQ and again on entry to RESP, and increments every cycle spent in REQ or RESP.
  - When the count reaches `TIMEOUT` and no `mem_gnt`/`mem_rvalid` arrives that cycle: pulse `bus_err`, pulse `wb_valid` with `wb_we` = 0, drop `mem_req`, return to IDLE.
  - A grant or response arriving in the same cycle as expiry wins over the timeout.
- Width rules:
  - All data is 16 bits, no extension.
  - The timeout counter is `$clog2(TIMEOUT+1)` bits and saturates, never wrapping.

## Timing
- Reset (asynchronous, `rst_n` low):
  - State = IDLE.
  - `ex_ready` = 1 once `rst_n` is high.
  - `mem_req`, `mem_we`, `wb_valid`, `wb_we`, `bus_err` = 0.
  - `mem_addr`, `mem_wdata`, `wb_rd`, `wb_data` = 0.
- Reset mid-access aborts the access: any pending request is dropped and no writeback is produced.
- Latencies, with acceptance at edge N:
  - ALU op: `wb_valid` during cycle N+1. Back-to-back ALU ops give one writeback per cycle.
  - Store or load: `mem_req` high from cycle N+1.
  - Store granted in cycle G: `wb_valid` in cycle G+1.
  - Load with `mem_rvalid` in cycle R: `wb_valid` in cycle R+1.
  - Minimum load latency is 3 cycles (grant at N+1, response at N+2, writeback at N+3).
- `ex_ready` drops in cycle N+1 for memory ops and rises in the cycle `wb_valid` is asserted. A new instruction may be accepted at the edge that ends that cycle.

## Structure
- Shared package `cpu_pkg` holds:
  - the state enum (IDLE/REQ/RESP),
  - the 16-bit word width constant,
  - the register-index width (3).
- Sub-module `mem_timeout_ctr`: saturating counter with clear/enable inputs and an `expired` output, parameterised by `TIMEOUT`.

## Test plan
- **ALU passthrough:** three back-to-back non-memory ops with rd = 1, 2, 3 and results 0x1234, 0xFFFF, 0x0000 -> `wb_valid` in three consecutive cycles with the same data, `wb_we` = 1 each, `ex_ready` held at 1.
- **Store:** addr 0x00A0, data 0xBEEF; grant delayed 2 cycles -> `mem_req`/`mem_we`/`mem_addr`/`mem_wdata` stable for 3 cycles, `wb_valid` with `wb_we` = 0 one cycle after the grant, `ex_ready` low throughout.
- **Load:** addr 0x0100, rd = 5; grant immediately, `mem_rvalid` 4 cycles later with 0xCAFE -> `wb_rd` = 5, `wb_data` = 0xCAFE, `wb_we` = 1. A spurious `mem_rvalid` in the grant cycle is ignored.
- **rd = 0 load:** rd = 0 load returns 0x5555 -> `wb_valid` = 1 with `wb_we` = 0.
- **Timeout:** `TIMEOUT` = 4, no grant -> `bus_err` and `wb_valid` (`wb_we` = 0) pulse after 5 cycles in REQ, `mem_req` drops. A grant arriving in the expiry cycle produces no `bus_err`.
- **Reset mid-access:** `rst_n` asserted while in RESP -> all outputs 0 asynchronously. After release, a late `mem_rvalid` produces no writeback, and a new ALU op completes normally.
